// File: rtl/exp_arbiter.sv
// ----------------------------------------------------------------------------
// exp_arbiter
//
// Exception arbiter placed directly in front of CP0. It edge-detects three
// external exception requests, holds them pending, masks and prioritises
// them, then strobes CP0 exception capture and redirects the PC to the
// handler vector of the winning source. In-service levels are tracked so
// that eret retires the current level.
//
// Build option:
//   EXP_ARBITER_NEST_EN  defined   -> a higher-priority source may pre-empt a
//                                     running lower-level handler; in_service
//                                     may hold several bits and eret clears
//                                     only the top one.
//                        undefined -> nothing is taken while any level is in
//                                     service; in_service is at most one-hot.
//
// Parameters:
//   VEC_BASE     handler vector base; source i vectors to VEC_BASE + 32*(i+1)
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   enable       CPU advancing this cycle (low = stall)
//   irq_in[2:0]  raw exception requests, bit 2 highest priority
//   irq_mask     per-source enable, 1 = allowed
//   ie           global exception enable
//   is_eret      current instruction is eret
//   pc_cur       PC of the current instruction (EPC is latched by CP0 itself)
//   has_exp      CP0 capture strobe, high for the single ENTER cycle
//   exp_code     CP0 cause select: 01/10/11 = source 0/1/2, 00 when idle
//   kill         squash the current instruction's writes (equals has_exp)
//   pc_redirect  next PC = pc_target
//   pc_target    handler vector of the taken source
//   ack          one-cycle one-hot acknowledge of the taken source
//   in_service   levels currently being handled
//
// FSM states:
//   state | meaning
//   RUN   | normal execution, arbitration and eret decode when enable is high
//   ENTER | one-cycle exception entry: strobe CP0, redirect, acknowledge
//   RET   | one-cycle return slot, no arbitration so the return target runs
// ----------------------------------------------------------------------------
module exp_arbiter #(
    parameter logic [31:0] VEC_BASE = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [2:0]  irq_in,
    input  logic [2:0]  irq_mask,
    input  logic        ie,
    input  logic        is_eret,
    input  logic [31:0] pc_cur,
    output logic        has_exp,
    output logic [1:0]  exp_code,
    output logic        kill,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [2:0]  ack,
    output logic [2:0]  in_service
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTER = 2'd1,
        RET   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  irq_q;
    logic [2:0]  pending;
    logic [2:0]  in_service_q;
    logic [1:0]  code_q;
    logic [31:0] target_q;

    logic [2:0]  rise;
    logic [2:0]  above;
    logic [2:0]  eligible;
    logic        win_valid;
    logic [1:0]  win_code;
    logic [2:0]  top_clr;
    logic        take;
    logic        retire;
    logic        in_enter;
    logic [2:0]  ack_vec;
    logic        unused_pc;

    // EPC capture happens inside CP0, so the PC is not needed here.
    assign unused_pc = ^pc_cur;

    // A rise on a request that is already pending simply re-sets the bit,
    // so it is never counted twice.
    assign rise = irq_in & ~irq_q;

    // above[i]: source i outranks every level currently in service.
`ifdef EXP_ARBITER_NEST_EN
    assign above = {~in_service_q[2], ~|in_service_q[2:1], ~|in_service_q};
`else
    assign above = {3{~|in_service_q}};
`endif

    assign eligible = pending & irq_mask & {3{ie}} & above;

    always_comb begin
        win_valid = 1'b1;
        win_code  = 2'd0;
        if (eligible[2]) begin
            win_code = 2'd3;
        end else if (eligible[1]) begin
            win_code = 2'd2;
        end else if (eligible[0]) begin
            win_code = 2'd1;
        end else begin
            win_valid = 1'b0;
        end
    end

    // Top set bit of in_service, i.e. the level eret retires.
    always_comb begin
        top_clr = 3'b000;
        if (in_service_q[2]) begin
            top_clr = 3'b100;
        end else if (in_service_q[1]) begin
            top_clr = 3'b010;
        end else if (in_service_q[0]) begin
            top_clr = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // eret has priority over a winner in the same RUN cycle.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        retire    = 1'b0;
        case (state)
            RUN: begin
                if (enable) begin
                    if (is_eret) begin
                        state_nxt = RET;
                        retire    = 1'b1;
                    end else if (win_valid) begin
                        state_nxt = ENTER;
                        take      = 1'b1;
                    end
                end
            end
            ENTER:   state_nxt = RUN;
            RET:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign in_enter = (state == ENTER);

    // The taken source is recovered from the registered cause code, so no
    // separate winner register is needed; code_q is only non-zero in ENTER.
    assign ack_vec = {3{in_enter}} & {code_q == 2'd3, code_q == 2'd2, code_q == 2'd1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q        <= 3'b000;
            pending      <= 3'b000;
            in_service_q <= 3'b000;
            code_q       <= 2'd0;
            target_q     <= VEC_BASE;
        end else begin
            irq_q <= irq_in;

            // New edge on the acknowledged source wins over the ENTER clear.
            pending <= (pending & ~ack_vec) | rise;

            if (in_enter) begin
                in_service_q <= in_service_q | ack_vec;
            end else if (retire) begin
                in_service_q <= in_service_q & ~top_clr;
            end

            if (take) begin
                code_q   <= win_code;
                target_q <= VEC_BASE + {25'd0, win_code, 5'd0};
            end else if (in_enter) begin
                code_q <= 2'd0;
            end
        end
    end

    assign has_exp     = in_enter;
    assign kill        = in_enter;
    assign pc_redirect = in_enter;
    assign ack         = ack_vec;
    assign exp_code    = code_q;
    assign pc_target   = target_q;
    assign in_service  = in_service_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_exp_arbiter
//
// Directed bench for exp_arbiter. Each expected exception entry is queued
// (cycle, cause code, vector, ack) when its stimulus is driven; every cycle
// the DUT outputs are compared against the queue head if it is due, or
// against the idle pattern otherwise. in_service and reset values are
// checked at chosen points. Set EXP_ARBITER_NEST_EN to match the RTL build.
// ----------------------------------------------------------------------------
module tb_exp_arbiter;

    localparam logic [31:0] VEC = 32'h0000_4000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [2:0]  irq_in;
    logic [2:0]  irq_mask;
    logic        ie;
    logic        is_eret;
    logic [31:0] pc_cur;
    logic        has_exp;
    logic [1:0]  exp_code;
    logic        kill;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [2:0]  ack;
    logic [2:0]  in_service;

    typedef struct {
        int          cyc;
        logic [1:0]  code;
        logic [31:0] target;
        logic [2:0]  ackv;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    exp_arbiter #(.VEC_BASE(VEC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .ie          (ie),
        .is_eret     (is_eret),
        .pc_cur      (pc_cur),
        .has_exp     (has_exp),
        .exp_code    (exp_code),
        .kill        (kill),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .ack         (ack),
        .in_service  (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_enter(input int at, input int code);
        exp_t       e;
        logic [2:0] one;
        one      = 3'b001;
        e.cyc    = at;
        e.code   = code[1:0];
        e.target = VEC + 32'(code * 32);
        e.ackv   = one << (code - 1);
        sb.push_back(e);
    endtask

    // One clock: advance past the rising edge, then check on the falling edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("enter_strobes", {29'd0, has_exp, kill, pc_redirect}, 32'h7);
            chk("enter_code", {30'd0, exp_code}, {30'd0, e.code});
            chk("enter_target", pc_target, e.target);
            chk("enter_ack", {29'd0, ack}, {29'd0, e.ackv});
        end else begin
            chk("idle_outputs", {24'd0, has_exp, kill, pc_redirect, ack, exp_code}, 32'h0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_eret();
        is_eret = 1'b1;
        run(1);
        is_eret = 1'b0;
        run(2);
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        enable      = 1'b1;
        irq_in      = 3'b000;
        irq_mask    = 3'b111;
        ie          = 1'b1;
        is_eret     = 1'b0;
        pc_cur      = 32'h0000_1000;

        // Reset values
        run(2);
        chk("reset_target", pc_target, VEC);
        chk("reset_in_service", {29'd0, in_service}, 32'h0);
        rst_n = 1'b1;
        run(2);

        // Single request on source 0
        irq_in = 3'b001;
        expect_enter(cyc + 2, 1);
        run(1);
        irq_in = 3'b000;
        run(3);
        chk("basic_in_service", {29'd0, in_service}, 32'h1);
        do_eret();
        chk("basic_eret", {29'd0, in_service}, 32'h0);

        // Two sources at once: 2 first, 1 held until eret + RET
        irq_in = 3'b110;
        expect_enter(cyc + 2, 3);
        run(4);
        chk("pair_first", {29'd0, in_service}, 32'h4);
        run(3);
        expect_enter(cyc + 3, 2);
        do_eret();
        run(2);
        chk("pair_second", {29'd0, in_service}, 32'h2);
        irq_in = 3'b000;
        do_eret();
        chk("pair_eret", {29'd0, in_service}, 32'h0);

        // eret beats an eligible request in the same RUN cycle
        irq_in = 3'b001;
        run(1);
        irq_in  = 3'b000;
        is_eret = 1'b1;
        expect_enter(cyc + 3, 1);
        run(1);
        is_eret = 1'b0;
        run(4);
        chk("eret_first", {29'd0, in_service}, 32'h1);
        do_eret();
        chk("eret_first_clr", {29'd0, in_service}, 32'h0);

        // Stall holds off entry; pending accumulates while stalled
        enable = 1'b0;
        irq_in = 3'b010;
        run(1);
        irq_in = 3'b000;
        run(5);
        chk("stall_none", {29'd0, in_service}, 32'h0);
        enable = 1'b1;
        expect_enter(cyc + 1, 2);
        run(3);
        chk("stall_taken", {29'd0, in_service}, 32'h2);
        do_eret();
        chk("stall_clr", {29'd0, in_service}, 32'h0);

        // Masked source stays pending until unmasked
        irq_mask = 3'b110;
        irq_in   = 3'b001;
        run(1);
        irq_in = 3'b000;
        run(4);
        irq_mask = 3'b111;
        expect_enter(cyc + 1, 1);
        run(3);
        chk("mask_taken", {29'd0, in_service}, 32'h1);

        // Higher source while level 0 is in service
        irq_in = 3'b100;
`ifdef EXP_ARBITER_NEST_EN
        expect_enter(cyc + 2, 3);
`endif
        run(1);
        irq_in = 3'b000;
        run(3);
`ifdef EXP_ARBITER_NEST_EN
        chk("nest_two_levels", {29'd0, in_service}, 32'h5);
        do_eret();
        chk("nest_pop_top", {29'd0, in_service}, 32'h1);
        do_eret();
        chk("nest_pop_all", {29'd0, in_service}, 32'h0);
`else
        chk("nonest_blocked", {29'd0, in_service}, 32'h1);
        expect_enter(cyc + 3, 3);
        do_eret();
        run(2);
        chk("nonest_after_eret", {29'd0, in_service}, 32'h4);
        do_eret();
        chk("nonest_clr", {29'd0, in_service}, 32'h0);
`endif

        // Global enable gates arbitration
        ie     = 1'b0;
        irq_in = 3'b100;
        run(1);
        irq_in = 3'b000;
        run(3);
        ie = 1'b1;
        expect_enter(cyc + 1, 3);
        run(3);
        chk("ie_taken", {29'd0, in_service}, 32'h4);
        do_eret();
        chk("ie_clr", {29'd0, in_service}, 32'h0);

        // New edge on the taken source during ENTER keeps it pending
        enable = 1'b0;
        irq_in = 3'b001;
        run(1);
        irq_in = 3'b000;
        run(1);
        enable = 1'b1;
        expect_enter(cyc + 1, 1);
        run(1);
        irq_in = 3'b001;
        run(1);
        irq_in = 3'b000;
        run(1);
        chk("setwin_in_service", {29'd0, in_service}, 32'h1);
        expect_enter(cyc + 3, 1);
        do_eret();
        run(2);
        chk("setwin_retaken", {29'd0, in_service}, 32'h1);
        do_eret();
        chk("setwin_clr", {29'd0, in_service}, 32'h0);

        // Reset during ENTER clears outputs at once and drops pending
        irq_in = 3'b010;
        expect_enter(cyc + 2, 2);
        run(1);
        irq_in = 3'b000;
        run(1);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {24'd0, has_exp, kill, pc_redirect, ack, exp_code}, 32'h0);
        chk("rst_target", pc_target, VEC);
        chk("rst_in_service", {29'd0, in_service}, 32'h0);
        run(2);
        rst_n = 1'b1;
        run(4);
        chk("rst_no_retrigger", {29'd0, in_service}, 32'h0);
        irq_in = 3'b010;
        expect_enter(cyc + 2, 2);
        run(1);
        irq_in = 3'b000;
        run(3);
        chk("rst_new_edge", {29'd0, in_service}, 32'h2);
        do_eret();
        chk("rst_new_clr", {29'd0, in_service}, 32'h0);
        run(2);

        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
